bitmap_blit_ctrl: RTL and testbench
===================================

Name: bitmap_blit_ctrl

Overview:
- Line-buffered controller that sequences the 32-row x 64-column bitmap ROM onto the VGA pixel stream at a movable origin, with optional integer upscaling.
- Once per scanline, during horizontal blanking, it fetches the needed ROM row into a 64-bit line buffer, then shifts it out pixel by pixel as the beam crosses the sprite.
- Sits between the VGA sync generator and the pixel mux in the game top level.

Parameters:
- SCALE_LOG2, 0: each ROM bit is drawn as a (1<<SCALE_LOG2)-pixel square. Legal range 0..2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_tick  in  1  pixel-enable strobe, one clk wide
- line_start  in  1  one-clk pulse in horizontal blanking before each active line
- next_y  in  10  index of the line about to be displayed; valid with line_start
- pix_x  in  10  current pixel column; valid on pix_tick
- video_on  in  1  active-video flag
- org_x  in  10  sprite left column; sampled on line_start
- org_y  in  10  sprite top line; sampled on line_start
- rom_addr  out  5  ROM row address, registered
- rom_data  in  64  ROM row, combinational from rom_addr, bit [0] = leftmost pixel
- pix_on  out  1  sprite pixel lit, registered
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, any state): state=IDLE; rom_addr=0, pix_on=0, busy=0; line buffer, column counter and sub-pixel counter cleared.
- Geometry: W = 64<<SCALE_LOG2 and H = 32<<SCALE_LOG2, computed at 11 bits to avoid overflow.
- IDLE, on line_start:
  - latch org_x and org_y into ox/oy;
  - if oy <= next_y < oy+H: drive rom_addr = (next_y-oy)>>SCALE_LOG2 and go to FETCH;
  - otherwise stay in IDLE.
- FETCH, 1 clk: line_buf <= rom_data; go to ARMED.
- ARMED: wait for pix_tick with pix_x == ox. On that tick:
  - pix_on <= line_buf[0] & video_on;
  - col=0, sub=1 (sub=0 if SCALE_LOG2=0);
  - go to DRAW.
- DRAW, on each pix_tick:
  - sub increments modulo 1<<SCALE_LOG2; col increments when sub wraps;
  - pix_on <= line_buf[col] & video_on;
  - after the pixel with col=63 and sub=max, the next pix_tick sets pix_on=0 and the state goes to IDLE.
- Latency: pix_on is registered on the pix_tick clk and reflects the pix_x presented on that tick. It is held until the next pix_tick.
- pix_on is 0 in every state except DRAW.
- line_start in FETCH, ARMED or DRAW aborts the current line: pix_on=0, then the IDLE line_start evaluation runs in that same cycle.
- Sprite clipped at the right edge: drawing continues until line_start aborts it. No wrap onto the next line.
- ox >= 1024-W: ARMED may never match; line_start recovers it.
- video_on low during DRAW: pix_on forced 0, counters keep advancing.
- org_x/org_y changes outside line_start have no effect until the next line.

Optional Feature:
- Macro: BLIT_FLIP_EN.
- Defined: adds input port flip_h (1 bit), sampled on line_start. When the latched value is 1, DRAW outputs line_buf[63-col] instead of line_buf[col].
- Undefined: port absent, normal column order.

Test Plan:
- Reset: assert reset for 2 clks mid-DRAW -> pix_on=0, busy=0, rom_addr=0 on the following clk. The next line_start behaves normally.
- Basic row: SCALE_LOG2=0, org=(100,50), rom_data=64'h8000_0000_0000_0001 for all rows, line_start with next_y=50 -> rom_addr=0; pix_on=1 only on ticks with pix_x=100 and pix_x=163; IDLE after pix_x=164.
- Row select and miss: next_y=81 -> rom_addr=31. next_y=82 or 49 -> stays IDLE, busy=0, rom_addr unchanged.
- Scaling: SCALE_LOG2=1, org=(0,0), next_y=5 -> rom_addr=2. A bit set at column 3 lights pix_x=6 and 7; sprite ends at pix_x=127.
- Abort: line_start pulsed in DRAW at col=20 -> pix_on drops to 0, new row fetched, drawing restarts at ox.
- Flip (BLIT_FLIP_EN, flip_h=1): only bit [0] set -> pix_on=1 at pix_x=ox+63 only.

Source files
------------

// File: rtl/bitmap_blit_ctrl_if.sv
// Beam timing, sprite origin and ROM row signals between the VGA timing side and bitmap_blit_ctrl.
// flip_h exists only when BLIT_FLIP_EN is defined.
interface bitmap_blit_ctrl_if;
    logic        pix_tick;
    logic        line_start;
    logic [9:0]  next_y;
    logic [9:0]  pix_x;
    logic        video_on;
    logic [9:0]  org_x;
    logic [9:0]  org_y;
    logic [4:0]  rom_addr;
    logic [63:0] rom_data;
    logic        pix_on;
    logic        busy;
`ifdef BLIT_FLIP_EN
    logic        flip_h;

    modport master (output pix_tick, line_start, next_y, pix_x, video_on, org_x, org_y,
                    output rom_data, flip_h, input rom_addr, pix_on, busy);
    modport slave  (input pix_tick, line_start, next_y, pix_x, video_on, org_x, org_y,
                    input rom_data, flip_h, output rom_addr, pix_on, busy);
`else
    modport master (output pix_tick, line_start, next_y, pix_x, video_on, org_x, org_y,
                    output rom_data, input rom_addr, pix_on, busy);
    modport slave  (input pix_tick, line_start, next_y, pix_x, video_on, org_x, org_y,
                    input rom_data, output rom_addr, pix_on, busy);
`endif
endinterface

// File: rtl/bitmap_blit_ctrl.sv
// Line-buffered 64x32 bitmap blitter with integer upscale; BLIT_FLIP_EN adds horizontal mirroring.
// Latency: pix_on registered on the pix_tick clk for the pix_x of that tick, held to the next tick.
// No backpressure: follows the beam; line_start aborts any line in flight.
module bitmap_blit_ctrl #(
    parameter int SCALE_LOG2 = 0
) (
    input  logic               clk,
    input  logic               reset,
    bitmap_blit_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, ARMED, DRAW} state_t;

    localparam logic [10:0] H       = 11'(32 << SCALE_LOG2);
    localparam logic [1:0]  SUB_MAX = 2'((1 << SCALE_LOG2) - 1);

    state_t      state_q, state_d;
    logic [4:0]  rom_addr_q, rom_addr_d;
    logic        pix_on_q, pix_on_d;
    logic [63:0] line_buf_q, line_buf_d;
    logic [5:0]  col_q, col_d;
    logic [1:0]  sub_q, sub_d;
    logic [9:0]  ox_q, ox_d;
    logic [9:0]  oy_q, oy_d;
    logic        flip_q, flip_d;

    logic [10:0] dy;
    logic        hit;
    logic        match;
    logic        last;

    // dy[10] set means next_y lies above the sprite top.
    assign dy    = {1'b0, bus.next_y} - {1'b0, bus.org_y};
    assign hit   = !dy[10] && (dy < H);
    assign match = bus.pix_tick && (bus.pix_x == ox_q);
    // sub_q is the sub-pixel index of the next pixel; col_q is the column last drawn.
    assign last  = (col_q == 6'd63) && (sub_q == 2'd0);

    function automatic logic pick(input logic [63:0] b, input logic [5:0] c, input logic f);
        return b[f ? ~c : c];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.line_start) begin
            state_d = hit ? FETCH : IDLE;
        end else begin
            case (state_q)
                FETCH:   state_d = ARMED;
                ARMED:   if (match) state_d = DRAW;
                DRAW:    if (bus.pix_tick && last) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        pix_on_d   = pix_on_q;
        line_buf_d = line_buf_q;
        col_d      = col_q;
        sub_d      = sub_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        flip_d     = flip_q;
        if (bus.line_start) begin
            pix_on_d = 1'b0;
            ox_d     = bus.org_x;
            oy_d     = bus.org_y;
`ifdef BLIT_FLIP_EN
            flip_d   = bus.flip_h;
`else
            flip_d   = 1'b0;
`endif
            if (hit) rom_addr_d = 5'(dy >> SCALE_LOG2);
        end else begin
            case (state_q)
                FETCH: line_buf_d = bus.rom_data;
                ARMED: begin
                    if (match) begin
                        col_d    = 6'd0;
                        sub_d    = 2'd1 & SUB_MAX;
                        pix_on_d = pick(line_buf_q, 6'd0, flip_q) & bus.video_on;
                    end
                end
                DRAW: begin
                    if (bus.pix_tick) begin
                        if (last) begin
                            pix_on_d = 1'b0;
                        end else begin
                            col_d    = (sub_q == 2'd0) ? col_q + 6'd1 : col_q;
                            sub_d    = (sub_q + 2'd1) & SUB_MAX;
                            pix_on_d = pick(line_buf_q, col_d, flip_q) & bus.video_on;
                        end
                    end
                end
                default: pix_on_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_q <= '0;
            pix_on_q   <= 1'b0;
            line_buf_q <= '0;
            col_q      <= '0;
            sub_q      <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            flip_q     <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            pix_on_q   <= pix_on_d;
            line_buf_q <= line_buf_d;
            col_q      <= col_d;
            sub_q      <= sub_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            flip_q     <= flip_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.pix_on   = pix_on_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_bitmap_blit_ctrl.sv
// Directed bench for bitmap_blit_ctrl: one instance at SCALE_LOG2=0 and one at SCALE_LOG2=1.
module tb_bitmap_blit_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_tick = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  next_y = '0;
    logic [9:0]  pix_x = '0;
    logic        video_on = 1'b1;
    logic [9:0]  org_x = '0;
    logic [9:0]  org_y = '0;
    logic [63:0] rom [32];
`ifdef BLIT_FLIP_EN
    logic        flip_h = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitmap_blit_ctrl_if bus0 ();
    bitmap_blit_ctrl_if bus1 ();

    assign bus0.pix_tick   = pix_tick;
    assign bus0.line_start = line_start;
    assign bus0.next_y     = next_y;
    assign bus0.pix_x      = pix_x;
    assign bus0.video_on   = video_on;
    assign bus0.org_x      = org_x;
    assign bus0.org_y      = org_y;
    assign bus0.rom_data   = rom[bus0.rom_addr];
    assign bus1.pix_tick   = pix_tick;
    assign bus1.line_start = line_start;
    assign bus1.next_y     = next_y;
    assign bus1.pix_x      = pix_x;
    assign bus1.video_on   = video_on;
    assign bus1.org_x      = org_x;
    assign bus1.org_y      = org_y;
    assign bus1.rom_data   = rom[bus1.rom_addr];
`ifdef BLIT_FLIP_EN
    assign bus0.flip_h     = flip_h;
    assign bus1.flip_h     = flip_h;
`endif

    bitmap_blit_ctrl #(.SCALE_LOG2(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    bitmap_blit_ctrl #(.SCALE_LOG2(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input int x);
        pix_x    = 10'(x);
        pix_tick = 1'b1;
        step();
        pix_tick = 1'b0;
        step();
    endtask

    // line_start pulse followed by the FETCH clk, leaving the block ARMED on a hit.
    task automatic do_line(input int y, input int ox, input int oy);
        next_y     = 10'(y);
        org_x      = 10'(ox);
        org_y      = 10'(oy);
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        step();
    endtask

    task automatic set_rom_all(input logic [63:0] v);
        for (int i = 0; i < 32; i++) rom[i] = v;
    endtask

    task automatic test_reset();
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (bus0.pix_on !== 1'b0 || bus0.busy !== 1'b0 || bus0.rom_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_state got pix_on=%b busy=%b rom_addr=%0d exp 0/0/0",
                     bus0.pix_on, bus0.busy, bus0.rom_addr);
        end
        checks++;
        if (bus1.pix_on !== 1'b0 || bus1.busy !== 1'b0 || bus1.rom_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_state_s1 got pix_on=%b busy=%b rom_addr=%0d exp 0/0/0",
                     bus1.pix_on, bus1.busy, bus1.rom_addr);
        end
    endtask

    task automatic test_basic_row();
        logic exp_on, exp_busy;
        set_rom_all(64'h8000_0000_0000_0001);
        do_line(50, 100, 50);
        org_x = 10'd0;
        checks++;
        if (bus0.rom_addr !== 5'd0 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_fetch got rom_addr=%0d busy=%b exp 0/1", bus0.rom_addr, bus0.busy);
        end
        for (int x = 98; x <= 165; x++) begin
            do_tick(x);
            exp_on   = (x == 100) || (x == 163);
            exp_busy = (x < 164);
            checks++;
            if (bus0.pix_on !== exp_on || bus0.busy !== exp_busy) begin
                errors++;
                $display("FAIL basic_pix x=%0d got pix_on=%b busy=%b exp %b/%b",
                         x, bus0.pix_on, bus0.busy, exp_on, exp_busy);
            end
        end
    endtask

    task automatic test_row_select();
        do_line(81, 100, 50);
        checks++;
        if (bus0.rom_addr !== 5'd31 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL row_last got rom_addr=%0d busy=%b exp 31/1", bus0.rom_addr, bus0.busy);
        end
        do_line(82, 100, 50);
        checks++;
        if (bus0.rom_addr !== 5'd31 || bus0.busy !== 1'b0 || bus0.pix_on !== 1'b0) begin
            errors++;
            $display("FAIL row_miss_below got rom_addr=%0d busy=%b pix_on=%b exp 31/0/0",
                     bus0.rom_addr, bus0.busy, bus0.pix_on);
        end
        do_line(49, 100, 50);
        checks++;
        if (bus0.rom_addr !== 5'd31 || bus0.busy !== 1'b0) begin
            errors++;
            $display("FAIL row_miss_above got rom_addr=%0d busy=%b exp 31/0", bus0.rom_addr, bus0.busy);
        end
    endtask

    task automatic test_scaling();
        logic exp_on, exp_busy;
        set_rom_all(64'h0);
        rom[2] = 64'h8000_0000_0000_0008;
        do_line(5, 0, 0);
        checks++;
        if (bus1.rom_addr !== 5'd2 || bus1.busy !== 1'b1) begin
            errors++;
            $display("FAIL scale_row got rom_addr=%0d busy=%b exp 2/1", bus1.rom_addr, bus1.busy);
        end
        for (int x = 0; x <= 129; x++) begin
            do_tick(x);
            exp_on   = (x == 6) || (x == 7) || (x == 126) || (x == 127);
            exp_busy = (x < 128);
            checks++;
            if (bus1.pix_on !== exp_on || bus1.busy !== exp_busy) begin
                errors++;
                $display("FAIL scale_pix x=%0d got pix_on=%b busy=%b exp %b/%b",
                         x, bus1.pix_on, bus1.busy, exp_on, exp_busy);
            end
        end
    endtask

    task automatic test_abort();
        logic exp_on;
        set_rom_all(64'h0);
        rom[0] = 64'h0000_0000_0010_0001;
        rom[1] = 64'h0000_0000_0000_0003;
        do_line(50, 10, 50);
        for (int x = 10; x <= 30; x++) begin
            do_tick(x);
            exp_on = (x == 10) || (x == 30);
            checks++;
            if (bus0.pix_on !== exp_on) begin
                errors++;
                $display("FAIL abort_first x=%0d got %b exp %b", x, bus0.pix_on, exp_on);
            end
        end
        do_line(51, 10, 50);
        checks++;
        if (bus0.pix_on !== 1'b0 || bus0.rom_addr !== 5'd1 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_refetch got pix_on=%b rom_addr=%0d busy=%b exp 0/1/1",
                     bus0.pix_on, bus0.rom_addr, bus0.busy);
        end
        for (int x = 8; x <= 13; x++) begin
            do_tick(x);
            exp_on = (x == 10) || (x == 11);
            checks++;
            if (bus0.pix_on !== exp_on) begin
                errors++;
                $display("FAIL abort_restart x=%0d got %b exp %b", x, bus0.pix_on, exp_on);
            end
        end
    endtask

    task automatic test_video_off();
        logic [7:0] vo_tab  = 8'b1100_1111;
        logic [7:0] exp_tab = 8'b0100_0101;
        set_rom_all(64'h0000_0000_0000_0055);
        do_line(50, 0, 50);
        for (int x = 0; x < 8; x++) begin
            video_on = vo_tab[x];
            do_tick(x);
            checks++;
            if (bus0.pix_on !== exp_tab[x]) begin
                errors++;
                $display("FAIL video_off x=%0d got %b exp %b", x, bus0.pix_on, exp_tab[x]);
            end
        end
        video_on = 1'b1;
    endtask

    task automatic test_clip_right();
        logic exp_on;
        set_rom_all('1);
        do_line(50, 1000, 50);
        for (int x = 998; x <= 1023; x++) begin
            do_tick(x);
            exp_on = (x >= 1000);
            checks++;
            if (bus0.pix_on !== exp_on || bus0.busy !== 1'b1) begin
                errors++;
                $display("FAIL clip_right x=%0d got pix_on=%b busy=%b exp %b/1",
                         x, bus0.pix_on, bus0.busy, exp_on);
            end
        end
        do_line(300, 1000, 50);
        checks++;
        if (bus0.pix_on !== 1'b0 || bus0.busy !== 1'b0) begin
            errors++;
            $display("FAIL clip_recover got pix_on=%b busy=%b exp 0/0", bus0.pix_on, bus0.busy);
        end
    endtask

    task automatic test_reset_mid_draw();
        logic exp_on;
        set_rom_all(64'h0000_0000_0000_0001);
        do_line(53, 100, 50);
        for (int x = 100; x <= 105; x++) do_tick(x);
        checks++;
        if (bus0.rom_addr !== 5'd3 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre got rom_addr=%0d busy=%b exp 3/1", bus0.rom_addr, bus0.busy);
        end
        pix_x    = 10'd106;
        pix_tick = 1'b1;
        reset    = 1'b1;
        step();
        pix_tick = 1'b0;
        step();
        checks++;
        if (bus0.pix_on !== 1'b0 || bus0.busy !== 1'b0 || bus0.rom_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid got pix_on=%b busy=%b rom_addr=%0d exp 0/0/0",
                     bus0.pix_on, bus0.busy, bus0.rom_addr);
        end
        reset = 1'b0;
        do_line(51, 100, 50);
        checks++;
        if (bus0.rom_addr !== 5'd1 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_next got rom_addr=%0d busy=%b exp 1/1", bus0.rom_addr, bus0.busy);
        end
        for (int x = 99; x <= 101; x++) begin
            do_tick(x);
            exp_on = (x == 100);
            checks++;
            if (bus0.pix_on !== exp_on) begin
                errors++;
                $display("FAIL reset_redraw x=%0d got %b exp %b", x, bus0.pix_on, exp_on);
            end
        end
    endtask

`ifdef BLIT_FLIP_EN
    task automatic test_flip();
        logic exp_on;
        set_rom_all(64'h0000_0000_0000_0001);
        flip_h = 1'b1;
        do_line(50, 100, 50);
        flip_h = 1'b0;
        for (int x = 99; x <= 165; x++) begin
            do_tick(x);
            exp_on = (x == 163);
            checks++;
            if (bus0.pix_on !== exp_on) begin
                errors++;
                $display("FAIL flip x=%0d got %b exp %b", x, bus0.pix_on, exp_on);
            end
        end
    endtask
`endif

    initial begin
        set_rom_all(64'h0);
        test_reset();
        test_basic_row();
        test_row_select();
        test_scaling();
        test_abort();
        test_video_off();
        test_clip_right();
        test_reset_mid_draw();
`ifdef BLIT_FLIP_EN
        test_flip();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
